// File: rtl/calc_core_param_if.sv
// Keypad-side command strobe plus display, status and state-debug outputs of the calculator core.
interface calc_core_param_if #(
    parameter int NUM_DIGITS = 8
);
    logic [3:0]                 cmd;
    logic                       cmd_valid;
    logic [NUM_DIGITS-1:0][6:0] displays;
    logic [1:0]                 status;
    logic [2:0]                 EA;
    logic [2:0]                 PE;

    modport master (output cmd, cmd_valid, input displays, status, EA, PE);
    modport slave  (input cmd, cmd_valid, output displays, status, EA, PE);
endinterface

// File: rtl/calc_core_param.sv
// Signed decimal calculator core: BCD entry, add/sub/shift-add multiply, double-dabble to 7-segment digits.
module calc_core_param #(
    parameter int NUM_DIGITS = 8,
    parameter int DATA_W     = 32
) (
    input logic              clock,
    input logic              reset,
    calc_core_param_if.slave bus
);
    localparam int PW = 2 * DATA_W;
    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(DATA_W + 1);
    localparam int NW = $clog2(NUM_DIGITS + 1);

    typedef enum logic [2:0] {
        ENT_A = 3'd0, ENT_B = 3'd1, CALC = 3'd2, CONV = 3'd3, SHOW = 3'd4, ERR = 3'd5
    } state_t;
    typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2} op_t;
    typedef logic [NUM_DIGITS-1:0][6:0] disp_t;

    function automatic logic signed [PW-1:0] pow10(input int n);
        logic signed [PW-1:0] r;
        r = PW'(1);
        for (int i = 0; i < n; i++) r = r * PW'(10);
        return r;
    endfunction

    localparam logic signed [PW-1:0] MAXP = pow10(NUM_DIGITS) - PW'(1);
    localparam logic signed [PW-1:0] MAXN = pow10(NUM_DIGITS - 1) - PW'(1);
    localparam disp_t DISP_ZERO = {{((NUM_DIGITS - 1) * 7){1'b0}}, 7'h3F};
    localparam disp_t DISP_ERR  = {{((NUM_DIGITS - 1) * 7){1'b0}}, 7'h79};

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Right-aligned magnitude, leading zeros blank, optional '-' just left of the MS digit.
    function automatic disp_t fmt(input logic [BW-1:0] dig, input logic minus);
        disp_t r;
        int    n;
        n = 1;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (dig[4*i +: 4] != 4'd0) n = i + 1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i < n)                r[i] = seg7(dig[4*i +: 4]);
            else if (minus && i == n) r[i] = 7'h40;
            else                      r[i] = 7'h00;
        end
        return r;
    endfunction

    function automatic logic signed [DATA_W-1:0] bcd2bin(input logic [BW-1:0] d);
        logic signed [DATA_W-1:0] r;
        r = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--)
            r = r * DATA_W'(10) + DATA_W'(d[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [BW-1:0] dabble_adj(input logic [BW-1:0] d);
        logic [BW-1:0] r;
        r = d;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (d[4*i +: 4] >= 4'd5) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
        return r;
    endfunction

    function automatic logic out_of_range(input logic signed [PW-1:0] v);
        return (v > MAXP) || (v < -MAXN);
    endfunction

    state_t                   state, state_nxt;
    op_t                      op, op_cmd;
    logic signed [DATA_W-1:0] a_reg, res_reg, entry_val;
    logic        [DATA_W-1:0] b_reg, mag;
    logic signed [PW-1:0]     mcand, prod, a_ext, b_ext, sum_val, mul_val, calc_val;
    logic        [BW-1:0]     ent_bcd, ent_ins, conv_bcd;
    logic        [NW-1:0]     ent_cnt;
    logic        [CW-1:0]     cyc;
    logic                     neg;
    disp_t                    disp;
    logic        [1:0]        status_r;
    logic is_digit, is_op, is_bsp, is_eq, is_clr, ins_ok, calc_done, conv_done;

    always_comb begin
        is_digit = bus.cmd_valid && (bus.cmd <= 4'd9);
        is_op    = bus.cmd_valid && (bus.cmd >= 4'd10) && (bus.cmd <= 4'd12);
        is_bsp   = bus.cmd_valid && (bus.cmd == 4'd13);
        is_eq    = bus.cmd_valid && (bus.cmd == 4'd14);
        is_clr   = bus.cmd_valid && (bus.cmd == 4'd15);
        case (bus.cmd[1:0])
            2'b11:   op_cmd = OP_SUB;
            2'b00:   op_cmd = OP_MUL;
            default: op_cmd = OP_ADD;
        endcase
        // A leading zero never occupies a buffer slot.
        ins_ok    = is_digit && (ent_cnt != NW'(NUM_DIGITS)) && !((ent_cnt == '0) && (bus.cmd == 4'd0));
        ent_ins   = {ent_bcd[BW-5:0], bus.cmd};
        entry_val = bcd2bin(ent_bcd);
        a_ext     = {{DATA_W{a_reg[DATA_W-1]}}, a_reg};
        b_ext     = {{DATA_W{1'b0}}, b_reg};
        sum_val   = (op == OP_SUB) ? a_ext - b_ext : a_ext + b_ext;
        mul_val   = prod + (b_reg[0] ? mcand : '0);
        calc_val  = (op == OP_MUL) ? mul_val : sum_val;
        calc_done = (op != OP_MUL) || (cyc == CW'(DATA_W - 1));
        conv_done = (cyc == CW'(DATA_W));
    end

    always_comb begin
        state_nxt = state;
        if (is_clr) begin
            state_nxt = ENT_A;
        end else begin
            case (state)
                ENT_A:   if (is_op) state_nxt = ENT_B;
                ENT_B:   if (is_eq) state_nxt = CALC;
                CALC:    if (calc_done) state_nxt = out_of_range(calc_val) ? ERR : CONV;
                CONV:    if (conv_done) state_nxt = SHOW;
                SHOW: begin
                    if (is_digit)   state_nxt = ENT_A;
                    else if (is_op) state_nxt = ENT_B;
                end
                ERR:     state_nxt = ERR;
                default: state_nxt = ENT_A;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ENT_A;
            status_r <= 2'b00;
        end else begin
            state <= state_nxt;
            case (state_nxt)
                CALC, CONV: status_r <= 2'b01;
                ERR:        status_r <= 2'b10;
                default:    status_r <= 2'b00;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset || is_clr) begin
            a_reg   <= '0;
            b_reg   <= '0;
            op      <= OP_ADD;
            ent_bcd <= '0;
            ent_cnt <= '0;
            disp    <= DISP_ZERO;
        end else begin
            case (state)
                ENT_A, ENT_B, SHOW: begin
                    if (is_digit) begin
                        if (ins_ok) begin
                            ent_bcd <= ent_ins;
                            ent_cnt <= ent_cnt + NW'(1);
                        end
                        if (ins_ok || state == SHOW) disp <= fmt(ent_ins, 1'b0);
                    end else if (is_bsp && state != SHOW && ent_cnt != '0) begin
                        ent_bcd <= {4'd0, ent_bcd[BW-1:4]};
                        ent_cnt <= ent_cnt - NW'(1);
                        disp    <= fmt({4'd0, ent_bcd[BW-1:4]}, 1'b0);
                    end else if (is_op && (state != ENT_B || ent_cnt == '0)) begin
                        op <= op_cmd;
                        if (state != ENT_B) begin
                            a_reg   <= (state == SHOW) ? res_reg : entry_val;
                            ent_bcd <= '0;
                            ent_cnt <= '0;
                            disp    <= DISP_ZERO;
                        end
                    end else if (is_eq && state == ENT_B) begin
                        b_reg <= entry_val;
                        mcand <= a_ext;
                        prod  <= '0;
                        cyc   <= '0;
                    end
                end
                // Multiplier bits are consumed LSB first from b_reg; the final partial sum is folded into calc_val.
                CALC: begin
                    if (!calc_done) begin
                        prod  <= mul_val;
                        mcand <= mcand <<< 1;
                        b_reg <= b_reg >> 1;
                        cyc   <= cyc + CW'(1);
                    end else if (out_of_range(calc_val)) begin
                        disp <= DISP_ERR;
                    end else begin
                        res_reg  <= DATA_W'(calc_val);
                        mag      <= calc_val[PW-1] ? DATA_W'(-calc_val) : DATA_W'(calc_val);
                        neg      <= calc_val[PW-1];
                        conv_bcd <= '0;
                        cyc      <= '0;
                    end
                end
                CONV: begin
                    if (!conv_done) begin
                        {conv_bcd, mag} <= {dabble_adj(conv_bcd), mag} << 1;
                        cyc             <= cyc + CW'(1);
                    end else begin
                        disp    <= fmt(conv_bcd, neg);
                        ent_bcd <= '0;
                        ent_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.displays = disp;
    assign bus.status   = status_r;
    assign bus.EA       = state;
    assign bus.PE       = state_nxt;
endmodule
